// File: rtl/bbcore_seq_pkg.sv
// Shared encodings for the bbcore_seq block: precision modes and FSM states.
package bbcore_seq_pkg;

    typedef enum logic [1:0] {
        PREC_8B     = 2'd0,
        PREC_4B     = 2'd1,
        PREC_2B     = 2'd2,
        PREC_8B_ALT = 2'd3
    } prec_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/bbcore_seq_if.sv
// Command, data-beat and result signals of bbcore_seq bundled as one interface.
interface bbcore_seq_if #(
    parameter int N_AG   = 4,
    parameter int N_WG   = 4,
    parameter int LANES  = 16,
    parameter int ACC_W  = 24,
    parameter int BIAS_W = 16,
    parameter int LEN_W  = 8
);
    localparam int N_PE = N_AG * N_WG;

    logic                      i_Start;
    logic [LEN_W-1:0]          i_Len;
    logic [1:0]                i_Prec;
    logic                      i_Use_Bias;
    logic [BIAS_W*N_PE-1:0]    i_Bias;
    logic                      i_Abort;
    logic                      i_Vld;
    logic                      o_Rdy;
    logic [8*LANES*N_AG-1:0]   i_Act;
    logic [8*LANES*N_WG-1:0]   i_Weight;
    logic                      o_Vld;
    logic                      i_Rdy;
    logic [ACC_W*N_PE-1:0]     o_Psum;
    logic                      o_Busy;

    modport master (
        output i_Start, i_Len, i_Prec, i_Use_Bias, i_Bias, i_Abort,
        output i_Vld, i_Act, i_Weight, i_Rdy,
        input  o_Rdy, o_Vld, o_Psum, o_Busy
    );

    modport slave (
        input  i_Start, i_Len, i_Prec, i_Use_Bias, i_Bias, i_Abort,
        input  i_Vld, i_Act, i_Weight, i_Rdy,
        output o_Rdy, o_Vld, o_Psum, o_Busy
    );

endinterface

// File: rtl/bbcore_seq_pe.sv
// One processing element: precision-configurable signed dot product,
// one pipeline register, and a wrapping accumulator.
module bbcore_seq_pe
    import bbcore_seq_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int ACC_W  = 24,
    parameter int BIAS_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [8*LANES-1:0]       act,
    input  logic [8*LANES-1:0]       weight,
    input  prec_e                    prec,
    input  logic                     init,
    input  logic                     use_bias,
    input  logic [BIAS_W-1:0]        bias,
    input  logic                     beat,
    input  logic                     abort,
    output logic [ACC_W-1:0]         psum
);

    logic signed [ACC_W-1:0] dot8, dot4, dot2, dot;
    logic signed [ACC_W-1:0] pipe_q;
    logic                    pipe_vld_q;
    logic signed [ACC_W-1:0] acc_q;

    // Dot product of the current slices in all three precisions; sums are kept
    // ACC_W wide since the accumulator wraps modulo 2^ACC_W anyway.
    always_comb begin
        dot8 = '0;
        dot4 = '0;
        dot2 = '0;
        for (int unsigned k = 0; k < LANES; k++)
            dot8 = dot8 + ACC_W'($signed(act[8*k +: 8])) * ACC_W'($signed(weight[8*k +: 8]));
        for (int unsigned k = 0; k < 2*LANES; k++)
            dot4 = dot4 + ACC_W'($signed(act[4*k +: 4])) * ACC_W'($signed(weight[4*k +: 4]));
        for (int unsigned k = 0; k < 4*LANES; k++)
            dot2 = dot2 + ACC_W'($signed(act[2*k +: 2])) * ACC_W'($signed(weight[2*k +: 2]));
        case (prec)
            PREC_4B: dot = dot4;
            PREC_2B: dot = dot2;
            default: dot = dot8;
        endcase
    end

    // Pipeline stage and accumulator; abort drops the in-flight product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q     <= '0;
            pipe_vld_q <= 1'b0;
            acc_q      <= '0;
        end else if (abort) begin
            pipe_vld_q <= 1'b0;
        end else if (init) begin
            pipe_vld_q <= 1'b0;
            acc_q      <= use_bias ? ACC_W'($signed(bias)) : '0;
        end else begin
            pipe_vld_q <= beat;
            if (beat)
                pipe_q <= dot;
            if (pipe_vld_q)
                acc_q <= acc_q + pipe_q;
        end
    end

    assign psum = acc_q;

endmodule

// File: rtl/bbcore_seq.sv
// Sequencer for the N_AG x N_WG PE array: job FSM, beat counter, PE instances.
module bbcore_seq
    import bbcore_seq_pkg::*;
#(
    parameter int N_AG   = 4,
    parameter int N_WG   = 4,
    parameter int LANES  = 16,
    parameter int ACC_W  = 24,
    parameter int BIAS_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    bbcore_seq_if.slave bus
);

    localparam int N_PE = N_AG * N_WG;

    state_e                 state_q, state_nxt;
    logic [LEN_W-1:0]       len_q, cnt_q;
    prec_e                  prec_q;
    logic                   start, accept, last_beat;
    logic [ACC_W*N_PE-1:0]  psum_all;

    assign start     = (state_q == ST_IDLE) && bus.i_Start && !bus.i_Abort;
    assign accept    = (state_q == ST_ACC) && bus.i_Vld && !bus.i_Abort;
    assign last_beat = (cnt_q == len_q - LEN_W'(1));

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state_q <= ST_IDLE;
        else
            state_q <= state_nxt;
    end

    // Next-state and handshake outputs; abort overrides every transition.
    always_comb begin
        state_nxt  = state_q;
        bus.o_Rdy  = 1'b0;
        bus.o_Vld  = 1'b0;
        bus.o_Busy = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:  if (start) state_nxt = ST_ACC;
            ST_ACC: begin
                bus.o_Rdy = 1'b1;
                if (accept && last_beat) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_OUT;
            ST_OUT: begin
                bus.o_Vld = 1'b1;
                if (bus.i_Rdy) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
        if (bus.i_Abort)
            state_nxt = ST_IDLE;
    end

    // Job parameters latched at start; beat counter for the ACC phase.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q  <= '0;
            len_q  <= LEN_W'(1);
            prec_q <= PREC_8B;
        end else if (bus.i_Abort) begin
            cnt_q  <= '0;
        end else if (start) begin
            cnt_q  <= '0;
            len_q  <= (bus.i_Len == '0) ? LEN_W'(1) : bus.i_Len;
            prec_q <= prec_e'(bus.i_Prec);
        end else if (accept) begin
            cnt_q  <= cnt_q + LEN_W'(1);
        end
    end

    for (genvar g = 0; g < N_PE; g++) begin : g_pe
        bbcore_seq_pe #(
            .LANES  (LANES),
            .ACC_W  (ACC_W),
            .BIAS_W (BIAS_W)
        ) u_pe (
            .clk      (CLK),
            .rst_n    (RST),
            .act      (bus.i_Act[8*LANES*(g % N_AG) +: 8*LANES]),
            .weight   (bus.i_Weight[8*LANES*(g / N_AG) +: 8*LANES]),
            .prec     (prec_q),
            .init     (start),
            .use_bias (bus.i_Use_Bias),
            .bias     (bus.i_Bias[BIAS_W*g +: BIAS_W]),
            .beat     (accept),
            .abort    (bus.i_Abort),
            .psum     (psum_all[ACC_W*g +: ACC_W])
        );
    end

    assign bus.o_Psum = psum_all;

endmodule

// File: tb/tb_bbcore_seq.sv
// Directed self-checking bench for bbcore_seq (default build plus an ACC_W=12 build).
module tb_bbcore_seq;

    logic CLK = 1'b0;
    logic RST;
    int   n_assert = 0;
    int   n_fail   = 0;

    bbcore_seq_if a ();
    bbcore_seq_if #(.ACC_W(12)) b ();

    bbcore_seq u_dut (.CLK(CLK), .RST(RST), .bus(a));
    bbcore_seq #(.ACC_W(12)) u_dut12 (.CLK(CLK), .RST(RST), .bus(b));

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_psum_a(input string tag, input int exp);
        for (int p = 0; p < 16; p++)
            chk($sformatf("%s_pe%0d", tag, p), 64'($signed(a.o_Psum[24*p +: 24])), 64'(exp));
    endtask

    task automatic chk_ctl(input string tag, input logic rdy, input logic vld, input logic busy);
        chk({tag, "_rdy"},  64'(a.o_Rdy),  64'(rdy));
        chk({tag, "_vld"},  64'(a.o_Vld),  64'(vld));
        chk({tag, "_busy"}, 64'(a.o_Busy), 64'(busy));
    endtask

    initial begin
        RST = 1'b0;
        a.i_Start = 0; a.i_Len = '0; a.i_Prec = '0; a.i_Use_Bias = 0; a.i_Bias = '0;
        a.i_Abort = 0; a.i_Vld = 0; a.i_Act = '0; a.i_Weight = '0; a.i_Rdy = 0;
        b.i_Start = 0; b.i_Len = '0; b.i_Prec = '0; b.i_Use_Bias = 0; b.i_Bias = '0;
        b.i_Abort = 0; b.i_Vld = 0; b.i_Act = '0; b.i_Weight = '0; b.i_Rdy = 0;
        #2;
        chk_ctl("rst", 0, 0, 0);
        chk_psum_a("rst_psum", 0);
        tick(); tick();
        RST = 1'b1;

        // 8b job, one beat: 16 x (1*2) = 32
        a.i_Act = {64{8'h01}}; a.i_Weight = {64{8'h02}};
        a.i_Prec = 2'd0; a.i_Len = 8'd1; a.i_Start = 1;
        tick(); a.i_Start = 0;
        chk_ctl("t1_acc", 1, 0, 1);
        a.i_Vld = 1;
        tick(); a.i_Vld = 0;
        chk_ctl("t1_drain", 0, 0, 1);
        tick();
        chk_ctl("t1_out", 0, 1, 1);
        chk_psum_a("t1_psum", 32);
        a.i_Rdy = 1;
        tick(); a.i_Rdy = 0;
        chk_ctl("t1_idle", 0, 0, 0);

        // 4b job, three beats, bias 100: 100 + 3 x 32 x (-1*3) = -188; then hold
        a.i_Act = {64{8'hFF}}; a.i_Weight = {64{8'h33}};
        a.i_Bias = {16{16'd100}}; a.i_Use_Bias = 1;
        a.i_Prec = 2'd1; a.i_Len = 8'd3; a.i_Start = 1;
        tick(); a.i_Start = 0; a.i_Use_Bias = 0;
        a.i_Vld = 1;
        tick(); tick(); tick();
        a.i_Vld = 0;
        chk_ctl("t2_drain", 0, 0, 1);
        tick();
        chk_ctl("t2_out", 0, 1, 1);
        chk_psum_a("t2_psum", -188);
        a.i_Start = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("t2_hold%0d_vld", c), 64'(a.o_Vld), 64'(1));
            chk($sformatf("t2_hold%0d_pe0", c), 64'($signed(a.o_Psum[23:0])), -64'sd188);
            chk($sformatf("t2_hold%0d_pe15", c), 64'($signed(a.o_Psum[383:360])), -64'sd188);
        end
        a.i_Start = 0; a.i_Rdy = 1;
        tick(); a.i_Rdy = 0;
        chk_ctl("t2_idle", 0, 0, 0);
        tick();
        chk_ctl("t2_still_idle", 0, 0, 0);

        // 2b job, two beats with a stall between: 2 x 64 x (1*-2) = -256
        a.i_Act = {64{8'h55}}; a.i_Weight = {64{8'hAA}};
        a.i_Prec = 2'd2; a.i_Len = 8'd2; a.i_Start = 1;
        tick(); a.i_Start = 0;
        a.i_Vld = 1;
        tick(); a.i_Vld = 0;
        chk_ctl("t3_beat1", 1, 0, 1);
        tick();
        chk_ctl("t3_stall", 1, 0, 1);
        a.i_Vld = 1;
        tick(); a.i_Vld = 0;
        chk_ctl("t3_drain", 0, 0, 1);
        tick();
        chk_ctl("t3_out", 0, 1, 1);
        chk_psum_a("t3_psum", -256);
        a.i_Rdy = 1;
        tick(); a.i_Rdy = 0;

        // Length 0 acts as 1; precision 3 acts as 8b
        a.i_Act = {64{8'h01}}; a.i_Weight = {64{8'h02}};
        a.i_Prec = 2'd3; a.i_Len = 8'd0; a.i_Start = 1;
        tick(); a.i_Start = 0;
        a.i_Vld = 1;
        tick(); a.i_Vld = 0;
        chk_ctl("t4_drain", 0, 0, 1);
        tick();
        chk_ctl("t4_out", 0, 1, 1);
        chk_psum_a("t4_psum", 32);
        a.i_Rdy = 1;
        tick(); a.i_Rdy = 0;

        // ACC_W=12 wrap: 2 x 16 x 16129 = 516128, mod 4096 = 32
        b.i_Act = {64{8'h7F}}; b.i_Weight = {64{8'h7F}};
        b.i_Prec = 2'd0; b.i_Len = 8'd2; b.i_Start = 1;
        tick(); b.i_Start = 0;
        b.i_Vld = 1;
        tick(); tick();
        b.i_Vld = 0;
        tick();
        chk("t5_vld", 64'(b.o_Vld), 64'(1));
        for (int p = 0; p < 16; p++)
            chk($sformatf("t5_psum_pe%0d", p), 64'($signed(b.o_Psum[12*p +: 12])), 64'sd32);
        b.i_Rdy = 1;
        tick(); b.i_Rdy = 0;
        chk("t5_idle_busy", 64'(b.o_Busy), 64'(0));

        // Abort on beat 2 of 4 (with start asserted), then abort beating start in IDLE
        a.i_Prec = 2'd0; a.i_Len = 8'd4; a.i_Start = 1;
        tick(); a.i_Start = 0;
        a.i_Vld = 1;
        tick();
        a.i_Abort = 1; a.i_Start = 1;
        tick();
        chk_ctl("t6_abort", 0, 0, 0);
        tick();
        chk_ctl("t6_abort_start", 0, 0, 0);
        a.i_Abort = 0; a.i_Start = 0; a.i_Vld = 0;

        // Reset pulse in the middle of an ACC phase
        a.i_Start = 1;
        tick(); a.i_Start = 0;
        a.i_Vld = 1;
        tick(); a.i_Vld = 0;
        #2 RST = 1'b0;
        #1;
        chk_ctl("t7_rst", 0, 0, 0);
        chk_psum_a("t7_rst_psum", 0);
        #1 RST = 1'b1;

        // First job after reset release
        a.i_Len = 8'd1; a.i_Start = 1;
        tick(); a.i_Start = 0;
        a.i_Vld = 1;
        tick(); a.i_Vld = 0;
        tick();
        chk_ctl("t8_out", 0, 1, 1);
        chk_psum_a("t8_psum", 32);
        a.i_Rdy = 1;
        tick(); a.i_Rdy = 0;
        chk_ctl("t8_idle", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
